mmf_fir: RTL and testbench
==========================

MMF_FIR -- requirements
Module: mmf_fir

Interface
REQ-001 Parameter DATA_W, default 8: signed sample width.
REQ-002 Parameter COEF_W, default 8: signed weight width.
REQ-003 Parameter TAPS, default 4 (>=2): number of filter taps.
REQ-004 Derived: ADDR_W = max(1, clog2(TAPS)); OUT_W = DATA_W + COEF_W + clog2(TAPS).
REQ-005 Ports SHALL be as follows:
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush of sample history and pipeline; weights retained.
- in_valid  input  1  in_data is presented this cycle.
- in_data  input  DATA_W  signed sample.
- coef_we  input  1  weight write strobe.
- coef_addr  input  ADDR_W  tap index to write.
- coef_data  input  COEF_W  signed weight value.
- out_valid  output  1  one-cycle pulse, out_data is a new result.
- out_data  output  OUT_W  signed filter result; holds its value between pulses.

Function
REQ-006 Delay line tap[0..TAPS-1]: on an edge with in_valid=1 and clear=0, tap[0] SHALL take in_data and tap[k] SHALL take tap[k-1]; otherwise it holds.
REQ-007 Weight bank coef[0..TAPS-1]: on an edge with coef_we=1 and coef_addr<TAPS, coef[coef_addr] SHALL take coef_data; coef_addr>=TAPS SHALL be ignored with no state change.
REQ-008 Stage 1 (product register): at the edge after a sample is accepted, prod[k] SHALL capture full-precision signed tap[k]*coef[k] (DATA_W+COEF_W bits), using register values held just before that edge.
REQ-009 Stage 2 (sum register): at the following edge, out_data SHALL capture the sign-extended sum of all prod[k] to OUT_W bits; no truncation, no saturation; overflow is impossible by construction.
REQ-010 Latency: sample accepted at edge E -> out_valid=1 and updated out_data during the cycle after edge E+2; out_valid SHALL be 0 in all other cycles.
REQ-011 Throughput: one sample per cycle; back-to-back in_valid SHALL give back-to-back out_valid pulses.
REQ-012 Weight write at or before edge E SHALL apply to the sample accepted at E; a write at edge E+1 or later SHALL NOT.
REQ-013 Simultaneous coef_we and in_valid on one edge: both SHALL take effect; each is independent.
REQ-014 clear=1 at an edge: delay line and prod registers SHALL become 0, both pipeline valid flags SHALL become 0 (in-flight results discarded), out_valid SHALL be 0 next cycle, out_data SHALL hold; coef bank unchanged.
REQ-015 clear and in_valid on the same edge: clear SHALL win; the sample is discarded.
REQ-016 out_data SHALL change only at edges that raise out_valid.

Reset
REQ-017 reset_n=0 SHALL immediately, without a clock edge, force: delay line 0, prod registers 0, pipeline valid flags 0, out_valid 0, out_data 0.
REQ-018 During reset every coef[k] SHALL be forced to all-ones (-1 signed).
REQ-019 Reset assertion mid-stream SHALL discard all in-flight samples; the first out_valid after release SHALL come 2 edges after the first accepted sample.
REQ-020 in_valid, coef_we and clear SHALL be ignored while reset_n=0.

Verification (TAPS=4, DATA_W=8, COEF_W=8, OUT_W=18)
REQ-021 Default weights: release reset, stream 1,2,3,4 back-to-back -> out_valid on 4 consecutive cycles, out_data -1,-3,-6,-10, first pulse 2 edges after the first sample.
REQ-022 Impulse: write coef 1,2,3,4 to taps 0..3, stream 1,0,0,0,0 -> out_data 1,2,3,4,0.
REQ-023 Extremes: all coef -128, four samples -128 -> final out_data +65536; all coef 127, samples -128 -> -65024; no wrap.
REQ-024 Write/sample race: coef[0]=5 written on the same edge as sample 2 accepted (other coefs 0) -> result 10; coef[0]=7 written one edge later -> that result still 10, next sample 1 gives 7.
REQ-025 Clear mid-stream: 2 samples in flight, assert clear for one edge -> no out_valid for those samples, out_data holds, next sample 3 with coef 1,2,3,4 -> 3.
REQ-026 Async reset: drop reset_n between edges mid-stream -> out_valid and out_data go 0 before the next edge; coefs read back as -1 via a probe sample.

Source files
------------

// File: rtl/mmf_fir.sv
// mmf_fir: pipelined direct-form FIR filter with a writable weight bank.
//   A sample accepted on edge E is multiplied tap-by-tap on edge E+1 and
//   summed into out_data on edge E+2, where out_valid pulses for one cycle.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (weights reset to -1)
//   clear      synchronous flush of history and pipeline, weights kept
//   in_valid   in_data is presented this cycle
//   in_data    signed sample, DATA_W bits
//   coef_we    weight write strobe
//   coef_addr  tap index to write, ADDR_W bits (indices >= TAPS ignored)
//   coef_data  signed weight, COEF_W bits
//   out_valid  one-cycle pulse marking a new out_data
//   out_data   signed sum, OUT_W bits, held between pulses
module mmf_fir #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COEF_W = 8,
   parameter int unsigned TAPS   = 4,
   localparam int unsigned ADDR_W = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1,
   localparam int unsigned OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              coef_we,
   input  logic [ADDR_W-1:0] coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data
);

   localparam int unsigned PROD_W = DATA_W + COEF_W;

   logic [DATA_W-1:0] tap_q  [TAPS];
   logic [DATA_W-1:0] tap_d  [TAPS];
   logic [COEF_W-1:0] coef_q [TAPS];
   logic [COEF_W-1:0] coef_d [TAPS];
   logic [PROD_W-1:0] prod_q [TAPS];
   logic [PROD_W-1:0] prod_d [TAPS];

   logic             acc_q, acc_d;             // sample entered delay line
   logic             pv_q, pv_d;               // products are fresh
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic [OUT_W-1:0] sum_c;
   logic             accept_c;

   assign accept_c = in_valid & ~clear;

   // Delay line: clear wins over a coincident sample.
   always_comb begin
      for (int unsigned k = 0; k < TAPS; k++) begin
         tap_d[k] = tap_q[k];
      end
      if (clear) begin
         for (int unsigned k = 0; k < TAPS; k++) begin
            tap_d[k] = '0;
         end
      end else if (in_valid) begin
         tap_d[0] = in_data;
         for (int unsigned k = 1; k < TAPS; k++) begin
            tap_d[k] = tap_q[k-1];
         end
      end
   end

   // Weight bank: out-of-range addresses are dropped; independent of clear.
   always_comb begin
      for (int unsigned k = 0; k < TAPS; k++) begin
         coef_d[k] = coef_q[k];
      end
      if (coef_we && (32'(coef_addr) < TAPS)) begin
         coef_d[coef_addr] = coef_data;
      end
   end

   // Stage 1: operands are sign-extended to full width before multiplying
   // so the product is never truncated to the operand width.
   always_comb begin
      for (int unsigned k = 0; k < TAPS; k++) begin
         prod_d[k] = prod_q[k];
      end
      if (clear) begin
         for (int unsigned k = 0; k < TAPS; k++) begin
            prod_d[k] = '0;
         end
      end else if (acc_q) begin
         for (int unsigned k = 0; k < TAPS; k++) begin
            prod_d[k] = PROD_W'(PROD_W'($signed(tap_q[k])) * PROD_W'($signed(coef_q[k])));
         end
      end
   end

   // Stage 2 adder tree: each product sign-extended to the output width.
   always_comb begin
      sum_c = '0;
      for (int unsigned k = 0; k < TAPS; k++) begin
         sum_c = sum_c + OUT_W'($signed(prod_q[k]));
      end
   end

   // Valid pipeline and output register; out_data only moves with a pulse.
   always_comb begin
      acc_d       = accept_c;
      pv_d        = acc_q & ~clear;
      out_valid_d = pv_q & ~clear;
      out_data_d  = out_data_q;
      if (pv_q && !clear) begin
         out_data_d = sum_c;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < TAPS; k++) begin
            tap_q[k]  <= '0;
            coef_q[k] <= '1;
            prod_q[k] <= '0;
         end
         acc_q       <= 1'b0;
         pv_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         for (int unsigned k = 0; k < TAPS; k++) begin
            tap_q[k]  <= tap_d[k];
            coef_q[k] <= coef_d[k];
            prod_q[k] <= prod_d[k];
         end
         acc_q       <= acc_d;
         pv_q        <= pv_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_mmf_fir.sv
// tb_mmf_fir: self-checking bench for mmf_fir (TAPS=4, DATA_W=8, COEF_W=8).
//   A reference model updated at each rising edge pushes expected results,
//   tagged with the edge they must appear on, into a scoreboard queue that
//   is popped and compared on the following falling edges.
module tb_mmf_fir;

   localparam int DATA_W = 8;
   localparam int COEF_W = 8;
   localparam int TAPS   = 4;
   localparam int ADDR_W = 2;
   localparam int OUT_W  = 18;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              clear;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              coef_we;
   logic [ADDR_W-1:0] coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;

   mmf_fir #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OUT_W-1:0] data;
      int               due;
   } exp_t;

   exp_t             sb[$];
   int               m_tap  [TAPS];
   int               m_coef [TAPS];
   logic [OUT_W-1:0] last_out;
   int               cyc;
   int               checks;
   int               errors;

   task automatic model_reset();
      for (int k = 0; k < TAPS; k++) begin
         m_tap[k]  = 0;
         m_coef[k] = -1;
      end
      sb.delete();
      last_out = '0;
   endtask

   // Reference behaviour at a rising edge, using the inputs held across it.
   task automatic model_edge();
      exp_t e;
      int   s;
      if (!reset_n) begin
         model_reset();
         return;
      end
      cyc++;
      if (coef_we && (int'(coef_addr) < TAPS)) m_coef[coef_addr] = int'($signed(coef_data));
      if (clear) begin
         for (int k = 0; k < TAPS; k++) m_tap[k] = 0;
         sb.delete();
      end else if (in_valid) begin
         for (int k = TAPS - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
         m_tap[0] = int'($signed(in_data));
         s = 0;
         for (int k = 0; k < TAPS; k++) s += m_tap[k] * m_coef[k];
         e.data = OUT_W'(s);
         e.due  = cyc + 2;
         sb.push_back(e);
      end
   endtask

   // Scoreboard comparison of the DUT outputs, away from the rising edge.
   task automatic monitor();
      exp_t e;
      checks++;
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_spurious cyc=%0d got pulse data=%0d, required no pulse", cyc, $signed(out_data));
         end else begin
            e = sb.pop_front();
            if (e.due != cyc || out_data !== e.data) begin
               errors++;
               $display("FAIL out_result cyc=%0d got %0d, required %0d at cyc %0d",
                        cyc, $signed(out_data), $signed(e.data), e.due);
            end
            last_out = e.data;
         end
      end else begin
         if (out_valid !== 1'b0 || out_data !== last_out) begin
            errors++;
            $display("FAIL out_idle cyc=%0d got valid=%b data=%0d, required valid=0 data=%0d",
                     cyc, out_valid, $signed(out_data), $signed(last_out));
         end
         if (sb.size() != 0 && sb[0].due <= cyc) begin
            errors++;
            $display("FAIL out_missing cyc=%0d got no pulse, required %0d", cyc, $signed(sb[0].data));
            void'(sb.pop_front());
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, model the rising edge,
   // compare at the next falling edge.
   task automatic cycle(input logic iv, input int d, input logic we, input int a,
                        input int cd, input logic clr);
      in_valid  = iv;
      in_data   = DATA_W'(d);
      coef_we   = we;
      coef_addr = ADDR_W'(a);
      coef_data = COEF_W'(cd);
      clear     = clr;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      monitor();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic sample(input int d);
      cycle(1'b1, d, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic write_coef(input int a, input int cd);
      cycle(1'b0, 0, 1'b1, a, cd, 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle(2);
      // Writes and samples during reset must leave no trace.
      cycle(1'b1, 77, 1'b1, 0, 5, 1'b0);
      cycle(1'b1, 33, 1'b1, 1, 9, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_state got valid=%b data=%0d, required 0/0", out_valid, $signed(out_data));
      end
      reset_n = 1'b1;
      idle(2);
   endtask

   task automatic test_default_weights();
      for (int i = 1; i <= 4; i++) sample(i);
      idle(3);
      checks++;
      if (out_data !== OUT_W'(-10)) begin
         errors++;
         $display("FAIL default_final got %0d, required -10", $signed(out_data));
      end
   endtask

   task automatic test_impulse();
      cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      sample(1);
      for (int i = 0; i < 4; i++) sample(0);
      idle(3);
      checks++;
      if (out_data !== '0) begin
         errors++;
         $display("FAIL impulse_final got %0d, required 0", $signed(out_data));
      end
   endtask

   task automatic test_extremes();
      cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int k = 0; k < TAPS; k++) write_coef(k, -128);
      for (int i = 0; i < 4; i++) sample(-128);
      idle(3);
      checks++;
      if (out_data !== OUT_W'(65536)) begin
         errors++;
         $display("FAIL extreme_neg got %0d, required 65536", $signed(out_data));
      end
      cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int k = 0; k < TAPS; k++) write_coef(k, 127);
      for (int i = 0; i < 4; i++) sample(-128);
      idle(3);
      checks++;
      if (out_data !== OUT_W'(-65024)) begin
         errors++;
         $display("FAIL extreme_pos got %0d, required -65024", $signed(out_data));
      end
   endtask

   task automatic test_race();
      cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int k = 0; k < TAPS; k++) write_coef(k, 0);
      cycle(1'b1, 2, 1'b1, 0, 5, 1'b0);   // write lands with the sample
      write_coef(0, 7);                   // too late for that sample
      idle(1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== OUT_W'(10)) begin
         errors++;
         $display("FAIL race_same_edge got valid=%b data=%0d, required 1/10", out_valid, $signed(out_data));
      end
      sample(1);
      idle(2);
      checks++;
      if (out_valid !== 1'b1 || out_data !== OUT_W'(7)) begin
         errors++;
         $display("FAIL race_late_write got valid=%b data=%0d, required 1/7", out_valid, $signed(out_data));
      end
      idle(1);
   endtask

   task automatic test_clear();
      logic [OUT_W-1:0] held;
      cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      held = out_data;
      sample(5);
      sample(6);
      cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
      cycle(1'b1, 9, 1'b0, 0, 0, 1'b1);   // clear beats a coincident sample
      idle(3);
      checks++;
      if (out_data !== held) begin
         errors++;
         $display("FAIL clear_hold got %0d, required %0d", $signed(out_data), $signed(held));
      end
      sample(3);
      idle(2);
      checks++;
      if (out_valid !== 1'b1 || out_data !== OUT_W'(3)) begin
         errors++;
         $display("FAIL clear_resume got valid=%b data=%0d, required 1/3", out_valid, $signed(out_data));
      end
      idle(1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
               (i > 4) && ($urandom_range(0, 15) == 0));
      end
      idle(4);
   endtask

   task automatic test_async_reset();
      sample(4);
      sample(-3);
      sample(2);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL async_pre got valid=%b, required 1", out_valid);
      end
      #1;
      reset_n = 1'b0;                     // between edges
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL async_reset got valid=%b data=%0d, required 0/0", out_valid, $signed(out_data));
      end
      cycle(1'b1, 50, 1'b1, 2, 20, 1'b0);
      cycle(1'b1, 51, 1'b0, 0, 0, 1'b0);
      reset_n = 1'b1;
      idle(1);
      sample(1);
      idle(2);
      checks++;
      if (out_valid !== 1'b1 || out_data !== OUT_W'(-1)) begin
         errors++;
         $display("FAIL async_probe got valid=%b data=%0d, required 1/-1", out_valid, $signed(out_data));
      end
      idle(2);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      reset_n   = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      model_reset();
      test_reset();
      test_default_weights();
      test_impulse();
      test_extremes();
      test_race();
      test_clear();
      test_back_to_back();
      test_async_reset();
      idle(4);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
